// File: rtl/decode_queue.sv
// decode_queue: buffered RV32I decode stage between fetch and dispatch.
// A FIFO of (pc, inst) pairs feeds a registered, decoded output slot.
package decode_queue_pkg;
    localparam int OP_NOP   = 0;
    localparam int OP_ADD   = 1;
    localparam int OP_SUB   = 2;
    localparam int OP_SLL   = 3;
    localparam int OP_SLT   = 4;
    localparam int OP_SLTU  = 5;
    localparam int OP_XOR   = 6;
    localparam int OP_SRL   = 7;
    localparam int OP_SRA   = 8;
    localparam int OP_OR    = 9;
    localparam int OP_AND   = 10;
    localparam int OP_ADDI  = 11;
    localparam int OP_SLTI  = 12;
    localparam int OP_SLTIU = 13;
    localparam int OP_XORI  = 14;
    localparam int OP_ORI   = 15;
    localparam int OP_ANDI  = 16;
    localparam int OP_SLLI  = 17;
    localparam int OP_SRLI  = 18;
    localparam int OP_SRAI  = 19;
    localparam int OP_LB    = 20;
    localparam int OP_LH    = 21;
    localparam int OP_LW    = 22;
    localparam int OP_LBU   = 23;
    localparam int OP_LHU   = 24;
    localparam int OP_SB    = 25;
    localparam int OP_SH    = 26;
    localparam int OP_SW    = 27;
    localparam int OP_BEQ   = 28;
    localparam int OP_BNE   = 29;
    localparam int OP_BLT   = 30;
    localparam int OP_BGE   = 31;
    localparam int OP_BLTU  = 32;
    localparam int OP_BGEU  = 33;
    localparam int OP_LUI   = 34;
    localparam int OP_AUIPC = 35;
    localparam int OP_JAL   = 36;
    localparam int OP_JALR  = 37;
endpackage

module decode_queue
    import decode_queue_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int ADDR_W = 32,
    parameter int DEPTH  = 4,
    parameter int OP_W   = 6
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       rdy,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [ADDR_W-1:0]          in_pc,
    input  logic [31:0]                in_inst,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [ADDR_W-1:0]          out_pc,
    output logic [OP_W-1:0]            out_op,
    output logic [XLEN-1:0]            out_imm,
    output logic                       out_en_rx,
    output logic                       out_en_ry,
    output logic                       out_en_w,
    output logic [4:0]                 out_rs1,
    output logic [4:0]                 out_rs2,
    output logic [4:0]                 out_rd,
    output logic                       out_illegal,
    output logic [$clog2(DEPTH+1)-1:0] count
);
    localparam int CW = $clog2(DEPTH+1);
    localparam int PW = $clog2(DEPTH);

    logic [ADDR_W-1:0] pc_mem_q   [DEPTH];
    logic [31:0]       inst_mem_q [DEPTH];
    logic [PW-1:0]     wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              vld_q, vld_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [OP_W-1:0]   op_q, op_d;
    logic [XLEN-1:0]   imm_q, imm_d;
    logic              rx_q, rx_d, ry_q, ry_d, w_q, w_d, ill_q, ill_d;
    logic [4:0]        rs1_q, rs1_d, rs2_q, rs2_d, rd_q, rd_d;

    logic        push, load;
    logic [31:0] hd;
    logic [6:0]  opc, f7;
    logic [2:0]  f3;
    logic        f7_z, f7_alt;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j, d_imm;
    logic        d_rx, d_ry, d_w, d_ill;
    int          dop;
    logic [OP_W-1:0] dec_op;
    logic [XLEN-1:0] dec_imm;
    logic        dec_w;
    logic [4:0]  dec_rs1, dec_rs2, dec_rd;

    assign in_ready = !rst && (cnt_q != CW'(DEPTH));
    assign push = in_valid && in_ready && rdy;
    assign load = rdy && (cnt_q != '0) && (!vld_q || out_ready);

    assign hd     = inst_mem_q[rptr_q];
    assign opc    = hd[6:0];
    assign f3     = hd[14:12];
    assign f7     = hd[31:25];
    assign f7_z   = (f7 == 7'h00);
    assign f7_alt = (f7 == 7'h20);
    assign imm_i  = {{20{hd[31]}}, hd[31:20]};
    assign imm_s  = {{20{hd[31]}}, hd[31:25], hd[11:7]};
    assign imm_b  = {{19{hd[31]}}, hd[31], hd[7], hd[30:25],
                     hd[11:8], 1'b0};
    assign imm_u  = {hd[31:12], 12'b0};
    assign imm_j  = {{11{hd[31]}}, hd[31], hd[19:12], hd[20],
                     hd[30:21], 1'b0};

    always_comb begin
        dop   = OP_NOP;
        d_imm = '0;
        d_rx  = 1'b0;
        d_ry  = 1'b0;
        d_w   = 1'b0;
        d_ill = 1'b0;
        unique case (opc)
            7'b0010011: begin
                d_rx = 1'b1; d_w = 1'b1; d_imm = imm_i;
                case (f3)
                    3'd0: dop = OP_ADDI;
                    3'd1: begin dop = OP_SLLI; d_ill = !f7_z; end
                    3'd2: dop = OP_SLTI;
                    3'd3: dop = OP_SLTIU;
                    3'd4: dop = OP_XORI;
                    3'd5: begin
                        dop   = f7_alt ? OP_SRAI : OP_SRLI;
                        d_ill = !(f7_z || f7_alt);
                    end
                    3'd6: dop = OP_ORI;
                    default: dop = OP_ANDI;
                endcase
            end
            7'b0110011: begin
                d_rx = 1'b1; d_ry = 1'b1; d_w = 1'b1;
                // only ADD/SUB and SRL/SRA have an alternate funct7
                d_ill = !(f7_z || (f7_alt && (f3 == 3'd0 || f3 == 3'd5)));
                case (f3)
                    3'd0: dop = f7_alt ? OP_SUB : OP_ADD;
                    3'd1: dop = OP_SLL;
                    3'd2: dop = OP_SLT;
                    3'd3: dop = OP_SLTU;
                    3'd4: dop = OP_XOR;
                    3'd5: dop = f7_alt ? OP_SRA : OP_SRL;
                    3'd6: dop = OP_OR;
                    default: dop = OP_AND;
                endcase
            end
            7'b0000011: begin
                d_rx = 1'b1; d_w = 1'b1; d_imm = imm_i;
                case (f3)
                    3'd0: dop = OP_LB;
                    3'd1: dop = OP_LH;
                    3'd2: dop = OP_LW;
                    3'd4: dop = OP_LBU;
                    3'd5: dop = OP_LHU;
                    default: d_ill = 1'b1;
                endcase
            end
            7'b0100011: begin
                d_rx = 1'b1; d_ry = 1'b1; d_imm = imm_s;
                case (f3)
                    3'd0: dop = OP_SB;
                    3'd1: dop = OP_SH;
                    3'd2: dop = OP_SW;
                    default: d_ill = 1'b1;
                endcase
            end
            7'b1100011: begin
                d_rx = 1'b1; d_ry = 1'b1; d_imm = imm_b;
                case (f3)
                    3'd0: dop = OP_BEQ;
                    3'd1: dop = OP_BNE;
                    3'd4: dop = OP_BLT;
                    3'd5: dop = OP_BGE;
                    3'd6: dop = OP_BLTU;
                    3'd7: dop = OP_BGEU;
                    default: d_ill = 1'b1;
                endcase
            end
            7'b1100111: begin
                d_rx = 1'b1; d_w = 1'b1; d_imm = imm_i; dop = OP_JALR;
            end
            7'b0110111: begin d_w = 1'b1; d_imm = imm_u; dop = OP_LUI; end
            7'b0010111: begin d_w = 1'b1; d_imm = imm_u; dop = OP_AUIPC; end
            7'b1101111: begin d_w = 1'b1; d_imm = imm_j; dop = OP_JAL; end
            7'b0001111: dop = OP_NOP;
            default:    d_ill = 1'b1;
        endcase
        if (d_ill) begin
            dop   = OP_NOP;
            d_imm = '0;
            d_rx  = 1'b0;
            d_ry  = 1'b0;
            d_w   = 1'b0;
        end
    end

    assign dec_op  = OP_W'(dop);
    assign dec_imm = XLEN'($signed(d_imm));
    assign dec_rs1 = d_rx ? hd[19:15] : 5'd0;
    assign dec_rs2 = d_ry ? hd[24:20] : 5'd0;
    assign dec_w   = d_w && (hd[11:7] != 5'd0);
    assign dec_rd  = dec_w ? hd[11:7] : 5'd0;

    always_comb begin
        wptr_d = wptr_q; rptr_d = rptr_q; cnt_d = cnt_q; vld_d = vld_q;
        pc_d = pc_q; op_d = op_q; imm_d = imm_q; ill_d = ill_q;
        rx_d = rx_q; ry_d = ry_q; w_d = w_q;
        rs1_d = rs1_q; rs2_d = rs2_q; rd_d = rd_q;
        if (flush) begin
            wptr_d = '0; rptr_d = '0; cnt_d = '0; vld_d = 1'b0;
            pc_d = '0; op_d = OP_W'(OP_NOP); imm_d = '0; ill_d = 1'b0;
            rx_d = 1'b0; ry_d = 1'b0; w_d = 1'b0;
            rs1_d = '0; rs2_d = '0; rd_d = '0;
        end else if (rdy) begin
            if (push) wptr_d = wptr_q + PW'(1);
            if (load) begin
                rptr_d = rptr_q + PW'(1);
                vld_d  = 1'b1;
                pc_d   = pc_mem_q[rptr_q];
                op_d   = dec_op;  imm_d = dec_imm; ill_d = d_ill;
                rx_d   = d_rx;    ry_d  = d_ry;    w_d   = dec_w;
                rs1_d  = dec_rs1; rs2_d = dec_rs2; rd_d  = dec_rd;
            end else if (vld_q && out_ready) begin
                vld_d = 1'b0;
            end
            cnt_d = cnt_q + CW'(push) - CW'(load);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q <= '0; rptr_q <= '0; cnt_q <= '0; vld_q <= 1'b0;
            pc_q <= '0; op_q <= OP_W'(OP_NOP); imm_q <= '0; ill_q <= 1'b0;
            rx_q <= 1'b0; ry_q <= 1'b0; w_q <= 1'b0;
            rs1_q <= '0; rs2_q <= '0; rd_q <= '0;
        end else begin
            wptr_q <= wptr_d; rptr_q <= rptr_d; cnt_q <= cnt_d;
            vld_q <= vld_d; pc_q <= pc_d; op_q <= op_d;
            imm_q <= imm_d; ill_q <= ill_d;
            rx_q <= rx_d; ry_q <= ry_d; w_q <= w_d;
            rs1_q <= rs1_d; rs2_q <= rs2_d; rd_q <= rd_d;
        end
    end

    // storage needs no reset: entries are only read while counted valid
    always_ff @(posedge clk) begin
        if (push && !flush) begin
            pc_mem_q[wptr_q]   <= in_pc;
            inst_mem_q[wptr_q] <= in_inst;
        end
    end

    assign out_valid   = vld_q;
    assign out_pc      = pc_q;
    assign out_op      = op_q;
    assign out_imm     = imm_q;
    assign out_en_rx   = rx_q;
    assign out_en_ry   = ry_q;
    assign out_en_w    = w_q;
    assign out_rs1     = rs1_q;
    assign out_rs2     = rs2_q;
    assign out_rd      = rd_q;
    assign out_illegal = ill_q;
    assign count       = cnt_q;
endmodule

// File: tb/tb_decode_queue.sv
// tb_decode_queue: directed self-checking bench for decode_queue.
// Includes an XLEN=64 instance for the immediate sign-extension case.
module tb_decode_queue;
    import decode_queue_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, rdy, flush, in_valid, out_ready;
    logic [31:0] in_pc, in_inst;
    logic        in_ready, out_valid, out_en_rx, out_en_ry, out_en_w;
    logic        out_illegal;
    logic [31:0] out_pc, out_imm;
    logic [5:0]  out_op;
    logic [4:0]  out_rs1, out_rs2, out_rd;
    logic [2:0]  count;

    logic        v64_in, r64_in, v64_out, rdy64_out, rx64, ry64, w64, ill64;
    logic [31:0] pc64_in, inst64_in, pc64_out;
    logic [63:0] imm64;
    logic [5:0]  op64;
    logic [4:0]  rs1_64, rs2_64, rd64;
    logic [2:0]  cnt64;

    int n_checks = 0;
    int n_errors = 0;

    decode_queue dut (
        .clk(clk), .rst(rst), .rdy(rdy), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_pc(in_pc), .in_inst(in_inst),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .out_op(out_op), .out_imm(out_imm),
        .out_en_rx(out_en_rx), .out_en_ry(out_en_ry),
        .out_en_w(out_en_w), .out_rs1(out_rs1), .out_rs2(out_rs2),
        .out_rd(out_rd), .out_illegal(out_illegal), .count(count)
    );

    decode_queue #(.XLEN(64)) dut64 (
        .clk(clk), .rst(rst), .rdy(rdy), .flush(flush),
        .in_valid(v64_in), .in_ready(rdy64_out),
        .in_pc(pc64_in), .in_inst(inst64_in),
        .out_valid(v64_out), .out_ready(r64_in),
        .out_pc(pc64_out), .out_op(op64), .out_imm(imm64),
        .out_en_rx(rx64), .out_en_ry(ry64),
        .out_en_w(w64), .out_rs1(rs1_64), .out_rs2(rs2_64),
        .out_rd(rd64), .out_illegal(ill64), .count(cnt64)
    );

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_slot(input string tag, input logic [31:0] pc,
                               input int op, input logic [31:0] imm,
                               input logic rx, input logic ry,
                               input logic w, input logic [4:0] rs1,
                               input logic [4:0] rs2, input logic [4:0] rd,
                               input logic ill);
        check({tag, ".valid"}, out_valid, 1'b1);
        check({tag, ".pc"}, out_pc, pc);
        check({tag, ".op"}, out_op, op);
        check({tag, ".imm"}, out_imm, imm);
        check({tag, ".rx"}, out_en_rx, rx);
        check({tag, ".ry"}, out_en_ry, ry);
        check({tag, ".w"}, out_en_w, w);
        check({tag, ".rs1"}, out_rs1, rs1);
        check({tag, ".rs2"}, out_rs2, rs2);
        check({tag, ".rd"}, out_rd, rd);
        check({tag, ".ill"}, out_illegal, ill);
    endtask

    // add x3,x1,x2 / sub x4,x1,x2 / sw x2,-4(x1) / beq -8 / lw x5,8(x1)
    logic [31:0] fw [5] = '{32'h002081B3, 32'h40208233, 32'hFE20AE23,
                            32'hFE000CE3, 32'h0080A283};
    int exp_cnt [5] = '{1, 1, 2, 3, 4};
    logic exp_vld [5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1};

    initial begin
        rst = 1'b1; rdy = 1'b1; flush = 1'b0;
        in_valid = 1'b0; out_ready = 1'b0; in_pc = '0; in_inst = '0;
        v64_in = 1'b0; r64_in = 1'b0; pc64_in = '0; inst64_in = '0;
        step(); step();
        check("rst.in_ready", in_ready, 1'b0);
        check("rst.count", count, 0);
        check("rst.valid", out_valid, 1'b0);
        check("rst.op", out_op, OP_NOP);
        check("rst.pc", out_pc, 0);
        check("rst.imm", out_imm, 0);
        check("rst.w", out_en_w, 1'b0);
        check("rst.ill", out_illegal, 1'b0);
        rst = 1'b0;
        #1;
        check("in_ready", in_ready, 1'b1);

        // addi x1,x0,-1
        in_valid = 1'b1; in_pc = 32'h100; in_inst = 32'hFFF00093;
        step();
        in_valid = 1'b0;
        check("addi.cnt", count, 1);
        check("addi.nobypass", out_valid, 1'b0);
        step();
        expect_slot("addi", 32'h100, OP_ADDI, 32'hFFFFFFFF,
                    1, 0, 1, 0, 0, 1, 0);
        check("addi.cnt0", count, 0);
        out_ready = 1'b1;
        step();
        check("addi.drain", out_valid, 1'b0);
        out_ready = 1'b0;

        // fill to full with the output slot stalled
        for (int k = 0; k < 5; k++) begin
            in_valid = 1'b1; in_pc = 32'h200 + 4 * k; in_inst = fw[k];
            step();
            check("fill.cnt", count, exp_cnt[k]);
            check("fill.vld", out_valid, exp_vld[k]);
        end
        in_valid = 1'b0;
        check("full.in_ready", in_ready, 1'b0);
        expect_slot("add", 32'h200, OP_ADD, 0, 1, 1, 1, 1, 2, 3, 0);
        out_ready = 1'b1;
        step();
        expect_slot("sub", 32'h204, OP_SUB, 0, 1, 1, 1, 1, 2, 4, 0);
        check("drain.cnt3", count, 3);
        step();
        expect_slot("sw", 32'h208, OP_SW, 32'hFFFFFFFC,
                    1, 1, 0, 1, 2, 0, 0);
        check("drain.cnt2", count, 2);
        step();
        expect_slot("beq", 32'h20C, OP_BEQ, 32'hFFFFFFF8,
                    1, 1, 0, 0, 0, 0, 0);
        check("drain.cnt1", count, 1);
        step();
        expect_slot("lw", 32'h210, OP_LW, 8, 1, 0, 1, 1, 0, 5, 0);
        check("drain.cnt0", count, 0);
        step();
        check("drain.empty", out_valid, 1'b0);

        // streaming: nop-to-x0, unknown opcode, reserved funct7, fence
        in_valid = 1'b1; in_pc = 32'h300; in_inst = 32'h00000013;
        step();
        in_pc = 32'h304; in_inst = 32'h0000007F;
        step();
        expect_slot("addi_x0", 32'h300, OP_ADDI, 0, 1, 0, 0, 0, 0, 0, 0);
        in_pc = 32'h308; in_inst = 32'h022081B3;
        step();
        expect_slot("bad_opc", 32'h304, OP_NOP, 0, 0, 0, 0, 0, 0, 0, 1);
        in_pc = 32'h30C; in_inst = 32'h0000000F;
        step();
        check("bad_f7.op", out_op, OP_NOP);
        check("bad_f7.ill", out_illegal, 1'b1);
        check("bad_f7.pc", out_pc, 32'h308);
        in_valid = 1'b0;
        step();
        expect_slot("fence", 32'h30C, OP_NOP, 0, 0, 0, 0, 0, 0, 0, 0);
        step();
        check("stream.empty", out_valid, 1'b0);

        // rdy=0 freezes everything
        out_ready = 1'b0;
        in_valid = 1'b1; in_pc = 32'h400; in_inst = fw[0];
        step();
        in_pc = 32'h404; in_inst = fw[1];
        step();
        rdy = 1'b0; out_ready = 1'b1;
        in_pc = 32'h408; in_inst = fw[4];
        for (int k = 0; k < 3; k++) begin
            step();
            check("hold.cnt", count, 1);
            check("hold.vld", out_valid, 1'b1);
            check("hold.pc", out_pc, 32'h400);
            check("hold.op", out_op, OP_ADD);
        end
        rdy = 1'b1; in_valid = 1'b0;
        step();
        check("resume.pc", out_pc, 32'h404);
        check("resume.op", out_op, OP_SUB);
        check("resume.cnt", count, 0);
        step();
        check("resume.empty", out_valid, 1'b0);

        // flush a full queue while fetch presents a word
        out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            in_valid = 1'b1; in_pc = 32'h500 + 4 * k; in_inst = fw[k];
            step();
        end
        check("pre_flush.cnt", count, 4);
        flush = 1'b1; in_pc = 32'h600; in_inst = 32'hFFF00093;
        step();
        check("flush.cnt", count, 0);
        check("flush.vld", out_valid, 1'b0);
        check("flush.op", out_op, OP_NOP);
        check("flush.pc", out_pc, 0);
        check("flush.imm", out_imm, 0);
        check("flush.rx", out_en_rx, 1'b0);
        check("flush.rd", out_rd, 0);
        check("flush.in_ready", in_ready, 1'b1);
        step();
        check("flush.drop_cnt", count, 0);
        flush = 1'b0; in_valid = 1'b0;
        step();
        check("flush.drop_vld", out_valid, 1'b0);
        check("flush.drop_cnt2", count, 0);

        // queue restarts cleanly after flush
        in_valid = 1'b1; in_pc = 32'h700; in_inst = 32'hFFF00093;
        step();
        in_valid = 1'b0;
        step();
        expect_slot("post_flush", 32'h700, OP_ADDI, 32'hFFFFFFFF,
                    1, 0, 1, 0, 0, 1, 0);
        out_ready = 1'b1;
        step();
        check("post_flush.drain", out_valid, 1'b0);

        // lui x1,0x80000 on both widths
        in_valid = 1'b1; in_pc = 32'h800; in_inst = 32'h800000B7;
        v64_in = 1'b1; pc64_in = 32'h800; inst64_in = 32'h800000B7;
        step();
        in_valid = 1'b0; v64_in = 1'b0;
        step();
        expect_slot("lui32", 32'h800, OP_LUI, 32'h80000000,
                    0, 0, 1, 0, 0, 1, 0);
        check("lui64.vld", v64_out, 1'b1);
        check("lui64.op", op64, OP_LUI);
        check("lui64.imm", imm64, 64'hFFFFFFFF80000000);
        check("lui64.w", w64, 1'b1);
        check("lui64.rd", rd64, 1);
        check("lui64.rx", rx64, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
